// File: rtl/scrypt_pkg.sv
// scrypt_pkg: shared block width, default engine timeout and controller state encoding
package scrypt_pkg;
    localparam int BLOCK_W     = 1024;
    localparam int TIMEOUT_DEF = 64;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, OUT} state_e;
endpackage

// File: rtl/blockmix_iter_ctrl.sv
// blockmix_iter_ctrl: applies an external BlockMix engine N times to one block, with engine timeout
module blockmix_iter_ctrl
    import scrypt_pkg::*;
#(
    parameter int BLOCK_W = scrypt_pkg::BLOCK_W,
    parameter int ITER_W  = 16,
    parameter int TIMEOUT = scrypt_pkg::TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [BLOCK_W-1:0] s_data,
    input  logic [ITER_W-1:0]  s_iter,
    output logic               bm_init,
    output logic [BLOCK_W-1:0] bm_in,
    input  logic [BLOCK_W-1:0] bm_out,
    input  logic               bm_valid,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [BLOCK_W-1:0] m_data,
    output logic               err,
    output logic               busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    state_e state_q, state_d;
    logic [BLOCK_W-1:0] block_q, block_d;
    logic [ITER_W-1:0] rem_q, rem_d, rem_dec;
    logic [TW-1:0] tmo_q, tmo_d;
    assign rem_dec = rem_q - ITER_W'(1);
    assign s_ready = state_q == IDLE;
    assign bm_init = state_q == LAUNCH;
    assign m_valid = state_q == OUT;
    assign busy    = state_q != IDLE;
    assign bm_in   = block_q;
    assign m_data  = block_q;
    // state and datapath registers, cleared asynchronously so outputs drop at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            block_q <= '0;
            rem_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            block_q <= block_d;
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
        end
    end
    // next state: accept, launch, wait for engine (capture beats timeout), hold result
    always_comb begin
        state_d = state_q;
        block_d = block_q;
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        err     = 1'b0;
        case (state_q)
            IDLE: if (s_valid) begin
                block_d = s_data;
                rem_d   = s_iter;
                state_d = (s_iter != '0) ? LAUNCH : OUT;
            end
            LAUNCH: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (bm_valid) begin
                block_d = bm_out;
                rem_d   = rem_dec;
                state_d = (rem_dec != '0) ? LAUNCH : OUT;
            end else if (tmo_q == TMO_LAST) begin
                err     = 1'b1;
                block_d = '0;
                rem_d   = '0;
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
            OUT: if (m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_blockmix_iter_ctrl.sv
// tb_blockmix_iter_ctrl: directed checks of the iteration controller against a stub engine
module tb_blockmix_iter_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    logic s_valid, s_ready, bm_init, bm_valid, m_valid, m_ready, err, busy;
    logic [1023:0] s_data, bm_in, bm_out, m_data;
    logic [15:0] s_iter;
    int checks = 0;
    int passed = 0;
    int stub_lat;
    logic stub_act;
    int stub_cnt;
    logic [1023:0] stub_blk;
    int n_init = 0;
    int n_err = 0;
    int n_mv = 0;
    blockmix_iter_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_iter(s_iter),
        .bm_init(bm_init), .bm_in(bm_in), .bm_out(bm_out), .bm_valid(bm_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err(err), .busy(busy)
    );
    always #5 clk = ~clk;
    function automatic logic [1023:0] bmix(input logic [1023:0] x);
        return {x[1022:0], x[1023]} ^ {32{32'h9e3779b9}};
    endfunction
    // stub engine: result valid exactly stub_lat cycles after each bm_init cycle (0 = never)
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stub_act <= 1'b0;
            stub_cnt <= 0;
        end else if (bm_init) begin
            stub_act <= 1'b1;
            stub_cnt <= 1;
            stub_blk <= bm_in;
        end else if (stub_act) begin
            stub_cnt <= stub_cnt + 1;
            if (bm_valid) stub_act <= 1'b0;
        end
    end
    assign bm_valid = stub_act && stub_lat != 0 && stub_cnt == stub_lat;
    assign bm_out   = bmix(stub_blk);
    // event counters for pulses seen by the design's clock
    always @(posedge clk) begin
        if (bm_init) n_init <= n_init + 1;
        if (err) n_err <= n_err + 1;
        if (m_valid) n_mv <= n_mv + 1;
    end
    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs[95:0], exp[95:0]);
    endtask
    task automatic start(input logic [1023:0] d, input logic [15:0] it);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_iter  = it;
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask
    task automatic wait_mv(output int k);
        k = 1;
        @(negedge clk);
        while (!m_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [1023:0] x, y, held;
        int k, b_init, b_err, b_mv;
        logic ok;
        x = {16{64'h0123456789abcdef}};
        y = {32{32'hdeadbeef}} ^ {1000'd0, 24'h5a5a5a};
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_iter  = '0;
        m_ready = 1'b0;
        stub_lat = 5;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {s_ready, busy, m_valid, bm_init, err}, 5'b10000);
        reset_n = 1'b1;
        b_init = n_init;
        start(x, 16'd0);
        wait_mv(k);
        chk("pass_cycle", k, 1);
        chk("pass_data", m_data, x);
        chk("pass_no_init", n_init - b_init, 0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("pass_idle", {s_ready, busy, m_valid}, 3'b100);
        b_init = n_init;
        start(x, 16'd3);
        wait_mv(k);
        chk("iter_cycle", k, 19);
        chk("iter_data", m_data, bmix(bmix(bmix(x))));
        chk("iter_inits", n_init - b_init, 3);
        held = m_data;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            ok &= m_valid && !s_ready && m_data === held;
        end
        chk("bp_stable", ok, 1'b1);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("bp_idle", {s_ready, busy, m_valid}, 3'b100);
        stub_lat = 0;
        b_err = n_err;
        b_mv = n_mv;
        start(y, 16'd1);
        @(negedge clk);
        chk("tmo_launch", bm_init, 1'b1);
        repeat (63) @(negedge clk);
        chk("tmo_early", err, 1'b0);
        @(negedge clk);
        chk("tmo_err", {err, busy}, 2'b11);
        @(negedge clk);
        chk("tmo_idle", {err, s_ready, busy}, 3'b010);
        chk("tmo_err_once", n_err - b_err, 1);
        chk("tmo_no_mvalid", n_mv - b_mv, 0);
        stub_lat = 64;
        b_err = n_err;
        start(y, 16'd1);
        wait_mv(k);
        chk("edge_cycle", k, 66);
        chk("edge_data", m_data, bmix(y));
        chk("edge_no_err", n_err - b_err, 0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        stub_lat = 5;
        start(x, 16'd4);
        repeat (3) @(negedge clk);
        chk("rst_busy_before", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_immediate", {s_ready, busy, m_valid, bm_init, err}, 5'b10000);
        @(negedge clk);
        reset_n = 1'b1;
        start(y, 16'd1);
        wait_mv(k);
        chk("rst_after_cycle", k, 7);
        chk("rst_after_data", m_data, bmix(y));
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
